// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, then a sign-fix pass.
module mul_div_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;    // partial remainder / running product high half
  logic [31:0] quo_q, quo_d;    // dividend->quotient / multiplier->product low half
  logic [31:0] opnd_q, opnd_d;  // divisor or multiplicand magnitude
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum, shifted;
  logic [33:0] diff;
  logic [63:0] prod, prod_fix;

  assign accept = start && (state_q == StIdle || state_q == StDone);
  assign a_neg  = op[0] & srcA[31];
  assign b_neg  = op[0] & srcB[31];
  assign a_mag  = a_neg ? -srcA : srcA;
  assign b_mag  = b_neg ? -srcB : srcB;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (cnt_q == 5'd0) state_d = StFix;
      StFix:   if (cnt_q == 5'd0) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered status outputs follow the state being entered
  always_comb begin
    busy_d = (state_d == StRun) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  // Datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    sum      = rem_q + (quo_q[0] ? {1'b0, opnd_q} : 33'd0);
    shifted  = {rem_q[31:0], quo_q[31]};
    diff     = {1'b0, shifted} - {2'b00, opnd_q};
    prod     = {rem_q[31:0], quo_q};
    prod_fix = neg_lo_q ? -prod : prod;

    if (accept) begin
      cnt_d    = 5'd31;
      rem_d    = '0;
      is_div_d = op[1];
      quo_d    = op[1] ? a_mag : b_mag;
      opnd_d   = op[1] ? b_mag : a_mag;
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = op[1] ? a_neg : (a_neg ^ b_neg);
      dz_d     = op[1] && (srcB == 32'd0);
    end else begin
      case (state_q)
        StRun: begin
          cnt_d = (cnt_q == 5'd0) ? 5'd1 : cnt_q - 5'd1;
          if (is_div_q) begin
            if (!diff[33]) begin
              rem_d = diff[32:0];
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = shifted;
              quo_d = {quo_q[30:0], 1'b0};
            end
          end else begin
            rem_d = {1'b0, sum[32:1]};
            quo_d = {sum[0], quo_q[31:1]};
          end
        end
        StFix: begin
          if (cnt_q != 5'd0) begin
            cnt_d = 5'd0;
            if (is_div_q) begin
              // Divide-by-zero already leaves |A| as remainder; only the quotient is forced
              quo_d = dz_q ? 32'hFFFF_FFFF : (neg_lo_q ? -quo_q : quo_q);
              rem_d = {1'b0, (neg_hi_q ? -rem_q[31:0] : rem_q[31:0])};
            end else begin
              rem_d = {1'b0, prod_fix[63:32]};
              quo_d = prod_fix[31:0];
            end
          end else begin
            hi_d = rem_q[31:0];
            lo_d = quo_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed checks of mul_div_unit against a plain-arithmetic
// reference model: results, latency, busy/done behaviour and reset abort.
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] prev_exp;

  mul_div_unit dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, q, m;
    logic [63:0] r;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    case (o)
      2'd0: r = {32'd0, a} * {32'd0, b};
      2'd1: r = sa * sb;
      2'd2: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Issue one op; poke >= 0 pulses start that many cycles into RUN.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke);
    logic [63:0] exp;
    int lat;
    exp   = model(o, a, b);
    op    = o;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    op    = 2'($urandom);
    srcA  = $urandom;
    srcB  = $urandom;
    check_val("busy_run", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 60) begin
      start = (lat == poke);
      if (lat == 20) check_val("hold_prev", {hi, lo}, prev_exp);
      step();
      lat++;
    end
    start = 1'b0;
    check_val("latency", 64'(lat), 64'd34);
    check_val("result", {hi, lo}, exp);
    check_val("busy_done", 64'(busy), 64'd0);
    prev_exp = exp;
  endtask

  initial begin
    int seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    RST = 1'b1; start = 1'b0; op = '0; srcA = '0; srcB = '0;
    prev_exp = '0;
    step();
    step();
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_hilo", {hi, lo}, 64'd0);

    // First edge after release must accept
    RST = 1'b0;
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check_val("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    step();
    check_val("done_pulse", 64'(done), 64'd0);

    run_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, -1);
    check_val("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    step();
    run_op(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, -1);
    check_val("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    step();
    run_op(2'd2, 32'd100, 32'd7, -1);
    check_val("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    step();
    run_op(2'd2, 32'h1234_5678, 32'd0, -1);
    check_val("divu_zero", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    step();
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check_val("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    step();
    run_op(2'd3, 32'hFFFF_FFFB, 32'd0, -1);
    check_val("div_zero_neg", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    step();

    // Start pulsed mid-RUN is ignored
    run_op(2'd1, 32'h0001_2345, 32'hFFFF_0003, 5);
    step();
    check_val("done_pulse2", 64'(done), 64'd0);

    // Back-to-back: second start in the DONE cycle
    run_op(2'd0, 32'hDEAD_BEEF, 32'h0000_1234, -1);
    run_op(2'd3, 32'h7654_3210, 32'hFFFF_FF10, -1);
    step();
    check_val("done_b2b", 64'(done), 64'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000)) | (ra & 32'h8000_0000);
      run_op(ro, ra, rb, -1);
      if ($urandom_range(0, 2) != 0) step();
    end
    step();

    // Reset in RUN cycle 10, with a start in the reset cycle
    op = 2'd0; srcA = $urandom; srcB = $urandom; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    RST = 1'b1;
    start = 1'b1;
    step();
    RST = 1'b0;
    start = 1'b0;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_hilo", {hi, lo}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) seen++;
    end
    check_val("abort_quiet", 64'(seen), 64'd0);
    prev_exp = '0;

    run_op(2'd2, 32'hFFFF_FFFF, 32'd3, -1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
